// File: rtl/pixel_readout_pkg.sv
// Shared types for the pixel readout capture path: FSM states and the FIFO word.
package pixel_readout_pkg;

   localparam int ADDR_W     = 12;
   localparam int PIX_DATA_W = 14;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DATA = 2'd1,
      PUSH      = 2'd2
   } cap_state_t;

   typedef struct packed {
      logic [PIX_DATA_W-1:0] data;
      logic [ADDR_W-1:0]     row;
      logic [ADDR_W-1:0]     col;
      logic                  sof;
      logic                  eol;
      logic                  eof;
   } pix_word_t;

endpackage

// File: rtl/pixel_readout_capture_fifo.sv
// Synchronous FIFO with a registered head word, so the stream payload comes straight from flops.
module pix_sync_fifo #(
   parameter type word_t = logic [7:0],
   parameter int  DEPTH  = 16
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push,
   input  word_t                  wdata,
   input  logic                   pop,
   output word_t                  rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

   word_t         mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
   logic          wr_en, rd_en;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign rd_en   = pop && !empty;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign wr_en   = push && (!full || rd_en);
   assign rd_next = rd_ptr + AW'(rd_en);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         rdata  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         rdata  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr <= rd_next;
         level  <= level + (AW+1)'(wr_en) - (AW+1)'(rd_en);
         // The incoming word becomes the head only when it lands in the slot being read next.
         rdata  <= (wr_en && (rd_next == wr_ptr)) ? wdata : mem[rd_next];
      end
   end

endmodule

// File: rtl/pixel_readout_capture.sv
// Captures ADC samples on scan triggers and streams tagged pixels through a FIFO.
// Build option DARK_OFFSET_EN: subtract dark_offset from each sample, floored at zero.
module pixel_readout_capture
   import pixel_readout_pkg::*;
#(
   parameter int ADC_WIDTH    = 14,
   parameter int FIFO_DEPTH   = 16,
   parameter int CONV_TIMEOUT = 64
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        frame_reset,
   input  logic [ADDR_W-1:0]           row_start,
   input  logic [ADDR_W-1:0]           row_end,
   input  logic [ADDR_W-1:0]           col_start,
   input  logic [ADDR_W-1:0]           col_end,
   input  logic                        adc_start_trigger,
   input  logic [ADDR_W-1:0]           row_addr,
   input  logic [ADDR_W-1:0]           col_addr,
   output logic                        adc_conv_start,
   input  logic                        adc_data_valid,
   input  logic [ADC_WIDTH-1:0]        adc_data,
   input  logic [ADC_WIDTH-1:0]        dark_offset,
   output logic                        pix_valid,
   input  logic                        pix_ready,
   output logic [ADC_WIDTH-1:0]        pix_data,
   output logic [ADDR_W-1:0]           pix_row,
   output logic [ADDR_W-1:0]           pix_col,
   output logic                        pix_sof,
   output logic                        pix_eol,
   output logic                        pix_eof,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        overflow,
   output logic                        timeout_err,
   output logic                        trig_overrun
);

   localparam int            CW       = $clog2(CONV_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CONV_TIMEOUT - 1);

   cap_state_t           state, state_next;
   logic [CW-1:0]        wait_cnt_p1;
   logic [ADDR_W-1:0]    row_p0, col_p0;
   logic                 sof_p0, eol_p0, eof_p0;
   logic [ADC_WIDTH-1:0] data_p1;
   logic                 take_trig, take_data, conv_timeout, push_p2;
   pix_word_t            word_p2, head;
   logic                 fifo_full, fifo_empty, pop;

`ifdef DARK_OFFSET_EN
   function automatic logic [ADC_WIDTH-1:0] sat_sub(input logic [ADC_WIDTH-1:0] a,
                                                    input logic [ADC_WIDTH-1:0] b);
      logic signed [ADC_WIDTH:0] diff;
      diff = $signed({1'b0, a}) - $signed({1'b0, b});
      return (diff < 0) ? '0 : diff[ADC_WIDTH-1:0];
   endfunction
`else
   logic unused_dark;
   assign unused_dark = ^dark_offset;
`endif

   always_comb begin
      state_next   = state;
      take_trig    = 1'b0;
      take_data    = 1'b0;
      conv_timeout = 1'b0;
      push_p2      = 1'b0;
      case (state)
         IDLE: begin
            if (adc_start_trigger) begin
               take_trig  = 1'b1;
               state_next = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            if (adc_data_valid) begin
               take_data  = 1'b1;
               state_next = PUSH;
            end else if (wait_cnt_p1 == CNT_LAST) begin
               conv_timeout = 1'b1;
               state_next   = IDLE;
            end
         end
         PUSH: begin
            push_p2    = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // frame_reset outranks every event, so a late ADC response finds the FSM already idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         adc_conv_start <= 1'b0;
         wait_cnt_p1    <= '0;
         overflow       <= 1'b0;
         timeout_err    <= 1'b0;
         trig_overrun   <= 1'b0;
      end else if (frame_reset) begin
         state          <= IDLE;
         adc_conv_start <= 1'b0;
         wait_cnt_p1    <= '0;
         overflow       <= 1'b0;
         timeout_err    <= 1'b0;
         trig_overrun   <= 1'b0;
      end else begin
         state          <= state_next;
         adc_conv_start <= take_trig;
         wait_cnt_p1    <= (state == WAIT_DATA) ? wait_cnt_p1 + CW'(1) : '0;
         if (conv_timeout) timeout_err <= 1'b1;
         if (adc_start_trigger && (state != IDLE)) trig_overrun <= 1'b1;
         if (push_p2 && fifo_full && !pop) overflow <= 1'b1;
      end
   end

   // Stage p0: address and tags at trigger time; stage p1: ADC sample.
   always_ff @(posedge clk) begin
      if (take_trig) begin
         row_p0 <= row_addr;
         col_p0 <= col_addr;
         sof_p0 <= (row_addr == row_start) && (col_addr == col_start);
         eol_p0 <= (col_addr == col_end);
         eof_p0 <= (row_addr == row_end) && (col_addr == col_end);
      end
      if (take_data) data_p1 <= adc_data;
   end

   // Stage p2: assemble the FIFO word during PUSH.
   always_comb begin
      word_p2     = '0;
      word_p2.row = row_p0;
      word_p2.col = col_p0;
      word_p2.sof = sof_p0;
      word_p2.eol = eol_p0;
      word_p2.eof = eof_p0;
`ifdef DARK_OFFSET_EN
      word_p2.data = PIX_DATA_W'(sat_sub(data_p1, dark_offset));
`else
      word_p2.data = PIX_DATA_W'(data_p1);
`endif
   end

   assign pop = pix_valid && pix_ready;

   pix_sync_fifo #(
      .word_t (pix_word_t),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (frame_reset),
      .push  (push_p2),
      .wdata (word_p2),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign pix_valid = !fifo_empty;
   assign pix_data  = ADC_WIDTH'(head.data);
   assign pix_row   = head.row;
   assign pix_col   = head.col;
   assign pix_sof   = head.sof;
   assign pix_eol   = head.eol;
   assign pix_eof   = head.eof;
   assign busy      = (state != IDLE);

endmodule
